adc_map_multi: RTL and testbench

ADC_MAP_MULTI -- requirements
Module: adc_map_multi

---
 rtl/adc_map_multi.sv | 226 ++++++++++++++++++++++
 tb/tb_adc_map_multi.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_map_multi.sv
// Multi-lane ADC mapper: per-lane source select, block averaging, zero/gain/center
// mapping with saturation, and shadow->active configuration commit with flush.
module adc_map_multi #(
  parameter int unsigned ADC_WIDTH = 12,
  parameter int unsigned NUM_SRC   = 2,
  parameter int unsigned NUM_LANE  = 3,
  parameter int unsigned OUT_WIDTH = 32,
  parameter int unsigned KF_WIDTH  = 16,
  parameter int unsigned AVG_MAX   = 4
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic                                   cfg_we,
  input  logic [(NUM_LANE > 1 ? $clog2(NUM_LANE) : 1)-1:0] cfg_lane,
  input  logic [1:0]                             cfg_addr,
  input  logic [31:0]                            cfg_wdata,
  input  logic                                   cfg_commit,
  output logic                                   cfg_busy,
  input  logic                                   adc_valid,
  input  logic [NUM_SRC*ADC_WIDTH-1:0]           adc_data,
  input  logic [NUM_LANE-1:0]                    lane_en,
  output logic [NUM_LANE*OUT_WIDTH-1:0]          out_word,
  output logic [NUM_LANE-1:0]                    out_valid,
  output logic [NUM_LANE-1:0]                    sat_flag
);

  localparam int unsigned LW    = (NUM_LANE > 1) ? $clog2(NUM_LANE) : 1;
  localparam int unsigned PW    = ADC_WIDTH + KF_WIDTH;
  localparam int unsigned RW    = ((PW > OUT_WIDTH) ? PW : OUT_WIDTH) + 2;
  localparam int unsigned ACC_W = ADC_WIDTH + AVG_MAX;
  localparam int unsigned CNT_W = AVG_MAX + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_B1, ST_B2, ST_B3} state_e;

  state_e state_q, state_d;
  logic   busy_q;
  logic   commit_go;

  // Commit flush sequencer: busy for three cycles after an accepted commit
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  always_comb begin
    state_d   = state_q;
    commit_go = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_commit) begin
          commit_go = 1'b1;
          state_d   = ST_B3;
        end
      end
      ST_B3:   state_d = ST_B2;
      ST_B2:   state_d = ST_B1;
      ST_B1:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign cfg_busy = busy_q;

  logic [OUT_WIDTH-1:0] sh_center_q [NUM_LANE];
  logic [OUT_WIDTH-1:0] sh_center_d [NUM_LANE];
  logic [OUT_WIDTH-1:0] act_center_q[NUM_LANE];
  logic [KF_WIDTH-1:0]  sh_kf_q     [NUM_LANE];
  logic [KF_WIDTH-1:0]  sh_kf_d     [NUM_LANE];
  logic [KF_WIDTH-1:0]  act_kf_q    [NUM_LANE];
  logic [ADC_WIDTH-1:0] sh_zero_q   [NUM_LANE];
  logic [ADC_WIDTH-1:0] sh_zero_d   [NUM_LANE];
  logic [ADC_WIDTH-1:0] act_zero_q  [NUM_LANE];
  logic [7:0]           sh_ctrl_q   [NUM_LANE];
  logic [7:0]           sh_ctrl_d   [NUM_LANE];
  logic [7:0]           act_ctrl_q  [NUM_LANE];

  // Shadow write merged ahead of commit so a same-cycle write is committed
  always_comb begin
    for (int l = 0; l < NUM_LANE; l++) begin
      sh_center_d[l] = sh_center_q[l];
      sh_kf_d[l]     = sh_kf_q[l];
      sh_zero_d[l]   = sh_zero_q[l];
      sh_ctrl_d[l]   = sh_ctrl_q[l];
      if (cfg_we && (cfg_lane == LW'(l))) begin
        case (cfg_addr)
          2'd0:    sh_center_d[l] = OUT_WIDTH'(cfg_wdata);
          2'd1:    sh_kf_d[l]     = KF_WIDTH'(cfg_wdata);
          2'd2:    sh_zero_d[l]   = ADC_WIDTH'(cfg_wdata);
          default: sh_ctrl_d[l]   = 8'(cfg_wdata);
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int l = 0; l < NUM_LANE; l++) begin
        sh_center_q[l]  <= '0;
        sh_kf_q[l]      <= '0;
        sh_zero_q[l]    <= '0;
        sh_ctrl_q[l]    <= '0;
        act_center_q[l] <= '0;
        act_kf_q[l]     <= '0;
        act_zero_q[l]   <= '0;
        act_ctrl_q[l]   <= '0;
      end
    end else begin
      for (int l = 0; l < NUM_LANE; l++) begin
        sh_center_q[l] <= sh_center_d[l];
        sh_kf_q[l]     <= sh_kf_d[l];
        sh_zero_q[l]   <= sh_zero_d[l];
        sh_ctrl_q[l]   <= sh_ctrl_d[l];
        if (commit_go) begin
          act_center_q[l] <= sh_center_d[l];
          act_kf_q[l]     <= sh_kf_d[l];
          act_zero_q[l]   <= sh_zero_d[l];
          act_ctrl_q[l]   <= sh_ctrl_d[l];
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_LANE; g++) begin : g_lane
    logic [ACC_W-1:0]     acc_q, acc_d, sum;
    logic [CNT_W-1:0]     cnt_q, cnt_d, last_cnt;
    logic [3:0]           avg_l, src_sel;
    logic [ADC_WIDTH-1:0] smp, avg_q, avg_d, diff_q;
    logic [PW-1:0]        prod_q;
    logic [RW-1:0]        res;
    logic [OUT_WIDTH-1:0] word_q, word_c;
    logic                 v1_q, v1_d, v2_q, v3_q, ov_q;
    logic                 neg2_q, neg3_q, sat_q, sat_c, run;

    // A disabled lane or an accepted commit kills every stage of this lane
    assign run = lane_en[g] && !commit_go;

    // Source select and block accumulation
    always_comb begin
      src_sel  = act_ctrl_q[g][3:0];
      avg_l    = (act_ctrl_q[g][7:4] > 4'(AVG_MAX)) ? 4'(AVG_MAX) : act_ctrl_q[g][7:4];
      smp      = '0;
      for (int s = 0; s < NUM_SRC; s++) begin
        if (src_sel == 4'(s)) smp = adc_data[s*ADC_WIDTH +: ADC_WIDTH];
      end
      sum      = acc_q + ACC_W'(smp);
      last_cnt = CNT_W'((32'd1 << avg_l) - 32'd1);
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      avg_d    = avg_q;
      v1_d     = 1'b0;
      if (!run) begin
        acc_d = '0;
        cnt_d = '0;
      end else if (adc_valid) begin
        if (cnt_q == last_cnt) begin
          avg_d = ADC_WIDTH'(sum >> avg_l);
          v1_d  = 1'b1;
          acc_d = '0;
          cnt_d = '0;
        end else begin
          acc_d = sum;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    // Center offset with clamp to the unsigned output range
    always_comb begin
      res    = neg3_q ? (RW'(act_center_q[g]) - RW'(prod_q))
                      : (RW'(act_center_q[g]) + RW'(prod_q));
      word_c = res[OUT_WIDTH-1:0];
      sat_c  = 1'b0;
      if (res[RW-1]) begin
        word_c = '0;
        sat_c  = 1'b1;
      end else if (res[RW-2:OUT_WIDTH] != '0) begin
        word_c = '1;
        sat_c  = 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (!rstn) begin
        acc_q  <= '0;
        cnt_q  <= '0;
        avg_q  <= '0;
        v1_q   <= 1'b0;
        v2_q   <= 1'b0;
        v3_q   <= 1'b0;
        ov_q   <= 1'b0;
        neg2_q <= 1'b0;
        neg3_q <= 1'b0;
        diff_q <= '0;
        prod_q <= '0;
        word_q <= '0;
        sat_q  <= 1'b0;
      end else begin
        acc_q  <= acc_d;
        cnt_q  <= cnt_d;
        avg_q  <= avg_d;
        v1_q   <= v1_d;
        v2_q   <= v1_q && run;
        neg2_q <= (avg_q < act_zero_q[g]);
        diff_q <= (avg_q < act_zero_q[g]) ? (act_zero_q[g] - avg_q) : (avg_q - act_zero_q[g]);
        v3_q   <= v2_q && run;
        neg3_q <= neg2_q;
        prod_q <= PW'(diff_q) * PW'(act_kf_q[g]);
        ov_q   <= v3_q && run;
        if (v3_q && run) begin
          word_q <= word_c;
          sat_q  <= sat_c;
        end
      end
    end

    assign out_word[g*OUT_WIDTH +: OUT_WIDTH] = word_q;
    assign out_valid[g]                       = ov_q;
    assign sat_flag[g]                        = sat_q;
  end

endmodule

// File: tb/tb_adc_map_multi.sv
// Bench for adc_map_multi: spec-level arithmetic model with per-cycle compare,
// plus directed vectors with literal expectations.
module tb_adc_map_multi;
  localparam int NL = 3;
  localparam int NS = 2;
  localparam int AW = 12;
  localparam int OW = 32;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            cfg_we = 1'b0;
  logic [1:0]      cfg_lane = '0;
  logic [1:0]      cfg_addr = '0;
  logic [31:0]     cfg_wdata = '0;
  logic            cfg_commit = 1'b0;
  logic            cfg_busy;
  logic            adc_valid = 1'b0;
  logic [NS*AW-1:0] adc_data = '0;
  logic [NL-1:0]   lane_en = '0;
  logic [NL*OW-1:0] out_word;
  logic [NL-1:0]   out_valid;
  logic [NL-1:0]   sat_flag;

  int total = 0;
  int bad   = 0;

  adc_map_multi dut (
    .clk(clk), .rstn(rstn), .cfg_we(cfg_we), .cfg_lane(cfg_lane), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_commit(cfg_commit), .cfg_busy(cfg_busy),
    .adc_valid(adc_valid), .adc_data(adc_data), .lane_en(lane_en),
    .out_word(out_word), .out_valid(out_valid), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {int due; int lane; logic [31:0] w; logic s;} ent_t;
  ent_t pend[$];
  logic [31:0] sh_c[NL], ac_c[NL];
  logic [15:0] sh_k[NL], ac_k[NL];
  logic [11:0] sh_z[NL], ac_z[NL];
  logic [7:0]  sh_t[NL], ac_t[NL];
  longint      m_acc[NL];
  int          m_cnt[NL];
  int          busy_rem = 0;
  int          ecnt = 0;
  bit          armed = 0;
  logic [31:0] hold_w[NL];
  logic        hold_s[NL];

  function automatic void drop_lane(int l);
    ent_t keep[$];
    keep = {};
    foreach (pend[i]) if (pend[i].lane != l) keep.push_back(pend[i]);
    pend = keep;
  endfunction

  always @(posedge clk) begin : model
    bit go;
    int a, src;
    longint smp, avg, diff, res;
    bit neg, sat;
    ecnt++;
    if (!rstn) begin
      armed = 1;
      busy_rem = 0;
      pend.delete();
      for (int l = 0; l < NL; l++) begin
        sh_c[l] = 0; sh_k[l] = 0; sh_z[l] = 0; sh_t[l] = 0;
        ac_c[l] = 0; ac_k[l] = 0; ac_z[l] = 0; ac_t[l] = 0;
        m_acc[l] = 0; m_cnt[l] = 0; hold_w[l] = 0; hold_s[l] = 0;
      end
    end else begin
      if (cfg_we && cfg_lane < NL) begin
        case (cfg_addr)
          2'd0: sh_c[cfg_lane] = cfg_wdata;
          2'd1: sh_k[cfg_lane] = cfg_wdata[15:0];
          2'd2: sh_z[cfg_lane] = cfg_wdata[11:0];
          default: sh_t[cfg_lane] = cfg_wdata[7:0];
        endcase
      end
      go = cfg_commit && (busy_rem == 0);
      if (go) begin
        busy_rem = 3;
        pend.delete();
        for (int l = 0; l < NL; l++) begin
          ac_c[l] = sh_c[l]; ac_k[l] = sh_k[l]; ac_z[l] = sh_z[l]; ac_t[l] = sh_t[l];
          m_acc[l] = 0; m_cnt[l] = 0;
        end
      end else if (busy_rem > 0) begin
        busy_rem--;
      end
      for (int l = 0; l < NL; l++) begin
        if (!lane_en[l]) begin
          m_acc[l] = 0; m_cnt[l] = 0;
          drop_lane(l);
        end else if (!go && adc_valid) begin
          a   = (int'(ac_t[l][7:4]) > 4) ? 4 : int'(ac_t[l][7:4]);
          src = int'(ac_t[l][3:0]);
          smp = (src < NS) ? longint'(adc_data[src*AW +: AW]) : 0;
          m_acc[l] += smp;
          m_cnt[l]++;
          if (m_cnt[l] == (1 << a)) begin
            avg  = m_acc[l] >> a;
            neg  = avg < longint'(ac_z[l]);
            diff = neg ? longint'(ac_z[l]) - avg : avg - longint'(ac_z[l]);
            res  = neg ? longint'(ac_c[l]) - diff * longint'(ac_k[l])
                       : longint'(ac_c[l]) + diff * longint'(ac_k[l]);
            sat  = 0;
            if (res < 0) begin res = 0; sat = 1; end
            else if (res > 64'hFFFF_FFFF) begin res = 64'hFFFF_FFFF; sat = 1; end
            pend.push_back('{ecnt + 3, l, 32'(res), sat});
            m_acc[l] = 0; m_cnt[l] = 0;
          end
        end
      end
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin : compare
    bit ev[NL];
    if (armed) begin
      for (int l = 0; l < NL; l++) ev[l] = 0;
      for (int i = pend.size() - 1; i >= 0; i--) begin
        if (pend[i].due == ecnt) begin
          ev[pend[i].lane]     = 1;
          hold_w[pend[i].lane] = pend[i].w;
          hold_s[pend[i].lane] = pend[i].s;
          pend.delete(i);
        end
      end
      for (int l = 0; l < NL; l++) begin
        chk($sformatf("model valid[%0d] @%0d", l, ecnt), 32'(out_valid[l]), 32'(ev[l]));
        chk($sformatf("model word[%0d] @%0d", l, ecnt), out_word[l*OW +: OW], hold_w[l]);
        chk($sformatf("model sat[%0d] @%0d", l, ecnt), 32'(sat_flag[l]), 32'(hold_s[l]));
      end
      chk($sformatf("model busy @%0d", ecnt), 32'(cfg_busy), 32'(busy_rem > 0));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input int l, input int a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_lane = 2'(l); cfg_addr = 2'(a); cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic cfg_lane_all(input int l, input logic [31:0] c, input logic [31:0] k,
                              input logic [31:0] z, input logic [31:0] t);
    wr(l, 0, c); wr(l, 1, k); wr(l, 2, z); wr(l, 3, t);
  endtask

  task automatic commit_wait();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    repeat (3) tick();
  endtask

  task automatic samp(input logic [11:0] s0, input logic [11:0] s1);
    adc_valid = 1'b1; adc_data = {s1, s0};
    tick();
    adc_valid = 1'b0;
  endtask

  task automatic expect_lat(input int l, input logic [31:0] w, input logic s, input string name);
    for (int i = 1; i <= 3; i++) begin
      tick();
      if (i < 3) chk({name, " early"}, 32'(out_valid[l]), 32'd0);
    end
    chk({name, " valid"}, 32'(out_valid[l]), 32'd1);
    chk({name, " word"}, out_word[l*OW +: OW], w);
    chk({name, " sat"}, 32'(sat_flag[l]), 32'(s));
  endtask

  initial begin
    repeat (3) tick();
    rstn = 1'b1;
    chk("reset word0", out_word[31:0], 32'h0);
    chk("reset busy", 32'(cfg_busy), 32'd0);

    // Basic mapping, positive and negative offset
    cfg_lane_all(0, 32'h8000_0000, 32'h100, 32'h800, 32'h00);
    commit_wait();
    lane_en = 3'b001;
    samp(12'h900, 12'h0);
    expect_lat(0, 32'h8001_0000, 1'b0, "pos");
    samp(12'h700, 12'h0);
    expect_lat(0, 32'h7FFF_0000, 1'b0, "neg");

    // Saturation both ends
    wr(0, 0, 32'hFFFF_FFF0); wr(0, 1, 32'hFFFF); wr(0, 2, 32'h0);
    commit_wait();
    samp(12'hFFF, 12'h0);
    expect_lat(0, 32'hFFFF_FFFF, 1'b1, "sat hi");
    wr(0, 0, 32'h10); wr(0, 2, 32'hFFF);
    commit_wait();
    samp(12'h000, 12'h0);
    expect_lat(0, 32'h0000_0000, 1'b1, "sat lo");

    // Four-sample averaging
    cfg_lane_all(0, 32'h1000, 32'h1, 32'h800, 32'h20);
    commit_wait();
    samp(12'h800, 0); samp(12'h804, 0); samp(12'h808, 0); samp(12'h80C, 0);
    expect_lat(0, 32'h1006, 1'b0, "avg4");

    // Commit mid-block with same-cycle write and sample, plus an ignored commit
    samp(12'h800, 0); samp(12'h800, 0);
    cfg_we = 1'b1; cfg_lane = 2'd0; cfg_addr = 2'd0; cfg_wdata = 32'h2000;
    cfg_commit = 1'b1; adc_valid = 1'b1; adc_data = 24'h000900;
    tick();
    chk("busy c0", 32'(cfg_busy), 32'd1);
    cfg_addr = 2'd1; cfg_wdata = 32'h5; adc_data = 24'h000810;
    tick();
    cfg_we = 1'b0; cfg_commit = 1'b0; adc_valid = 1'b0;
    chk("busy c1", 32'(cfg_busy), 32'd1);
    samp(12'h810, 0);
    chk("busy c2", 32'(cfg_busy), 32'd1);
    samp(12'h810, 0);
    chk("busy c3", 32'(cfg_busy), 32'd0);
    samp(12'h810, 0);
    expect_lat(0, 32'h2010, 1'b0, "post commit");

    // Two lanes, one toggled off mid-block
    cfg_lane_all(0, 32'h1000, 32'h1, 32'h0, 32'h10);
    cfg_lane_all(1, 32'h3000, 32'h2, 32'h100, 32'h21);
    commit_wait();
    lane_en = 3'b011;
    for (int i = 0; i < 4; i++) samp(12'(12'h100 + 2 * i), 12'h120);
    expect_lat(1, 32'h3040, 1'b0, "lane1 first");
    samp(12'h110, 12'h130); samp(12'h110, 12'h130);
    lane_en = 3'b001;
    samp(12'h112, 12'h150); samp(12'h112, 12'h150);
    chk("lane1 hold", out_word[OW +: OW], 32'h3040);
    lane_en = 3'b011;
    samp(12'h114, 12'h140); samp(12'h114, 12'h140); samp(12'h114, 12'h140);
    samp(12'h116, 12'h140);
    expect_lat(1, 32'h3080, 1'b0, "lane1 restart");
    chk("lane0 word", out_word[OW-1:0], 32'h1115);

    // Out-of-range source, then averaging depth clamped to AVG_MAX
    cfg_lane_all(2, 32'h500, 32'h1, 32'h10, 32'h05);
    commit_wait();
    lane_en = 3'b100;
    samp(12'h7FF, 12'h7FF);
    expect_lat(2, 32'h4F0, 1'b0, "src oor");
    wr(2, 0, 32'h600); wr(2, 3, 32'h85);
    commit_wait();
    for (int i = 0; i < 15; i++) samp(12'h7FF, 12'h7FF);
    samp(12'h7FF, 12'h7FF);
    expect_lat(2, 32'h5F0, 1'b0, "avg clamp");

    // Reset with a result in flight
    lane_en = 3'b011;
    samp(12'h200, 12'h200); samp(12'h200, 12'h200);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk("rst word0", out_word[OW-1:0], 32'h0);
    chk("rst word1", out_word[OW +: OW], 32'h0);
    chk("rst valid", 32'(out_valid), 32'h0);
    samp(12'h123, 12'h0); samp(12'h456, 12'h0);
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
